// File: rtl/tcp_conn_ctrl.sv
// tcp_conn_ctrl: multi-connection TCP control FSM (RFC 793 states) with a per-connection 2MSL timer.
// Optional: define TCP_CTRL_RST_REPLY_EN to answer segments aimed at CLOSED/LISTEN connections with RST.
module tcp_conn_ctrl #(
  parameter int                     CONN_COUNT         = 4,
  parameter int                     TIMER_WIDTH        = 16,
  parameter logic [TIMER_WIDTH-1:0] DEFAULT_2MSL_TIMER = 16'h1000,
  localparam int                    CONN_ID_WIDTH      = (CONN_COUNT > 1) ? $clog2(CONN_COUNT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     timer_tick,
  input  logic [TIMER_WIDTH-1:0]   timeout_2msl_in,
  input  logic                     s_seg_valid,
  output logic                     s_seg_ready,
  input  logic [CONN_ID_WIDTH-1:0] s_seg_conn_id,
  input  logic                     s_seg_syn,
  input  logic                     s_seg_ack,
  input  logic                     s_seg_fin,
  input  logic                     s_seg_rst,
  input  logic                     s_cmd_valid,
  output logic                     s_cmd_ready,
  input  logic [CONN_ID_WIDTH-1:0] s_cmd_conn_id,
  input  logic [1:0]               s_cmd_op,
  output logic                     m_tx_valid,
  input  logic                     m_tx_ready,
  output logic [CONN_ID_WIDTH-1:0] m_tx_conn_id,
  output logic                     m_tx_syn,
  output logic                     m_tx_ack,
  output logic                     m_tx_fin,
  output logic                     m_tx_rst,
  input  logic [CONN_ID_WIDTH-1:0] stat_conn_id,
  output logic [3:0]               stat_state,
  output logic [CONN_COUNT-1:0]    conn_established,
  output logic                     evt_error
);

  localparam logic [3:0] ST_CLOSED      = 4'd0;
  localparam logic [3:0] ST_LISTEN      = 4'd1;
  localparam logic [3:0] ST_SYN_SENT    = 4'd2;
  localparam logic [3:0] ST_SYN_RCVD    = 4'd3;
  localparam logic [3:0] ST_ESTABLISHED = 4'd4;
  localparam logic [3:0] ST_FIN_WAIT_1  = 4'd5;
  localparam logic [3:0] ST_FIN_WAIT_2  = 4'd6;
  localparam logic [3:0] ST_CLOSING     = 4'd7;
  localparam logic [3:0] ST_TIME_WAIT   = 4'd8;
  localparam logic [3:0] ST_CLOSE_WAIT  = 4'd9;
  localparam logic [3:0] ST_LAST_ACK    = 4'd10;

  localparam logic [1:0] OP_NOP     = 2'd0;
  localparam logic [1:0] OP_ACTIVE  = 2'd1;
  localparam logic [1:0] OP_PASSIVE = 2'd2;
  localparam logic [1:0] OP_CLOSE   = 2'd3;

  localparam logic [CONN_ID_WIDTH:0] CONN_LIMIT = CONN_COUNT[CONN_ID_WIDTH:0];

  logic [3:0]             state_q [CONN_COUNT];
  logic [3:0]             state_d [CONN_COUNT];
  logic [TIMER_WIDTH-1:0] timer_q [CONN_COUNT];
  logic [TIMER_WIDTH-1:0] timer_d [CONN_COUNT];

  logic                     tx_valid_q, tx_valid_d;
  logic [CONN_ID_WIDTH-1:0] tx_conn_id_q, tx_conn_id_d;
  logic                     tx_syn_q, tx_syn_d;
  logic                     tx_ack_q, tx_ack_d;
  logic                     tx_fin_q, tx_fin_d;
  logic                     evt_error_q, evt_error_d;
  logic [3:0]               stat_state_q, stat_state_d;

  logic                     go, seg_fire, cmd_fire, ev_fire, id_ok;
  logic [CONN_ID_WIDTH-1:0] ev_id;
  logic [3:0]               cur_state;
  logic [TIMER_WIDTH-1:0]   tw_load;

  logic       seg_reject, ev_err, ev_tx, ev_syn, ev_ack, ev_fin, ev_tw;
  logic [3:0] ev_next;
`ifdef TCP_CTRL_RST_REPLY_EN
  logic       ev_rst, tx_rst_q, tx_rst_d;
`endif

  // Single output register: a new event is taken only when that register is free or draining.
  assign go          = ~tx_valid_q | m_tx_ready;
  assign s_seg_ready = go;
  assign s_cmd_ready = go & ~s_seg_valid;
  assign seg_fire    = s_seg_valid & go;
  assign cmd_fire    = s_cmd_valid & go & ~s_seg_valid;
  assign ev_fire     = seg_fire | cmd_fire;
  assign ev_id       = s_seg_valid ? s_seg_conn_id : s_cmd_conn_id;
  assign id_ok       = {1'b0, ev_id} < CONN_LIMIT;
  assign cur_state   = id_ok ? state_q[ev_id] : ST_CLOSED;
  assign tw_load     = (timeout_2msl_in == '0) ? DEFAULT_2MSL_TIMER : timeout_2msl_in;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ev_next    = cur_state;
    ev_err     = 1'b0;
    ev_tx      = 1'b0;
    ev_syn     = 1'b0;
    ev_ack     = 1'b0;
    ev_fin     = 1'b0;
    ev_tw      = 1'b0;
    seg_reject = 1'b0;
`ifdef TCP_CTRL_RST_REPLY_EN
    ev_rst     = 1'b0;
`endif
    if (seg_fire) begin
      if (!id_ok) begin
        ev_err = 1'b1;
      end else if (s_seg_rst) begin
        if (cur_state == ST_CLOSED || cur_state == ST_LISTEN) ev_err  = 1'b1;
        else                                                  ev_next = ST_CLOSED;
      end else begin
        case (cur_state)
          ST_CLOSED: seg_reject = 1'b1;
          ST_LISTEN:
            if (s_seg_syn) begin
              ev_next = ST_SYN_RCVD; ev_tx = 1'b1; ev_syn = 1'b1; ev_ack = 1'b1;
            end else seg_reject = 1'b1;
          ST_SYN_SENT:
            if (s_seg_syn && s_seg_ack) begin
              ev_next = ST_ESTABLISHED; ev_tx = 1'b1; ev_ack = 1'b1;
            end else if (s_seg_syn) begin
              ev_next = ST_SYN_RCVD; ev_tx = 1'b1; ev_syn = 1'b1; ev_ack = 1'b1;
            end else ev_err = 1'b1;
          ST_SYN_RCVD:
            if (s_seg_ack) ev_next = ST_ESTABLISHED;
            else           ev_err  = 1'b1;
          ST_ESTABLISHED:
            if (s_seg_fin) begin
              ev_next = ST_CLOSE_WAIT; ev_tx = 1'b1; ev_ack = 1'b1;
            end else ev_err = 1'b1;
          ST_FIN_WAIT_1:
            if (s_seg_fin && s_seg_ack) begin
              ev_next = ST_TIME_WAIT; ev_tx = 1'b1; ev_ack = 1'b1; ev_tw = 1'b1;
            end else if (s_seg_fin) begin
              ev_next = ST_CLOSING; ev_tx = 1'b1; ev_ack = 1'b1;
            end else if (s_seg_ack) ev_next = ST_FIN_WAIT_2;
            else ev_err = 1'b1;
          ST_FIN_WAIT_2, ST_TIME_WAIT:
            if (s_seg_fin) begin
              ev_next = ST_TIME_WAIT; ev_tx = 1'b1; ev_ack = 1'b1; ev_tw = 1'b1;
            end else ev_err = 1'b1;
          ST_CLOSING:
            if (s_seg_ack) begin
              ev_next = ST_TIME_WAIT; ev_tw = 1'b1;
            end else ev_err = 1'b1;
          ST_LAST_ACK:
            if (s_seg_ack) ev_next = ST_CLOSED;
            else           ev_err  = 1'b1;
          default: ev_err = 1'b1;
        endcase
      end
      if (seg_reject) begin
`ifdef TCP_CTRL_RST_REPLY_EN
        ev_tx  = 1'b1;
        ev_rst = 1'b1;
        ev_ack = ~s_seg_ack;
`else
        ev_err = 1'b1;
`endif
      end
    end else if (cmd_fire && s_cmd_op != OP_NOP) begin
      if (!id_ok) begin
        ev_err = 1'b1;
      end else begin
        case (cur_state)
          ST_CLOSED:
            if (s_cmd_op == OP_ACTIVE) begin
              ev_next = ST_SYN_SENT; ev_tx = 1'b1; ev_syn = 1'b1;
            end else if (s_cmd_op == OP_PASSIVE) ev_next = ST_LISTEN;
            else ev_err = 1'b1;
          ST_LISTEN, ST_SYN_SENT:
            if (s_cmd_op == OP_CLOSE) ev_next = ST_CLOSED;
            else                      ev_err  = 1'b1;
          ST_SYN_RCVD, ST_ESTABLISHED:
            if (s_cmd_op == OP_CLOSE) begin
              ev_next = ST_FIN_WAIT_1; ev_tx = 1'b1; ev_fin = 1'b1;
            end else ev_err = 1'b1;
          ST_CLOSE_WAIT:
            if (s_cmd_op == OP_CLOSE) begin
              ev_next = ST_LAST_ACK; ev_tx = 1'b1; ev_fin = 1'b1;
            end else ev_err = 1'b1;
          default: ev_err = 1'b1;
        endcase
      end
    end
  end

  // An event on a connection pre-empts its TIME_WAIT expiry; expiry is re-checked next cycle.
  always_comb begin
    for (int i = 0; i < CONN_COUNT; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      if (state_q[i] == ST_TIME_WAIT && timer_tick && timer_q[i] != '0)
        timer_d[i] = timer_q[i] - TIMER_WIDTH'(1);
      if (ev_fire && id_ok && ev_id == CONN_ID_WIDTH'(i)) begin
        state_d[i] = ev_next;
        if (ev_tw) timer_d[i] = tw_load;
      end else if (state_q[i] == ST_TIME_WAIT && timer_q[i] == '0) begin
        state_d[i] = ST_CLOSED;
      end
    end
  end

  always_comb begin
    tx_valid_d   = tx_valid_q;
    tx_conn_id_d = tx_conn_id_q;
    tx_syn_d     = tx_syn_q;
    tx_ack_d     = tx_ack_q;
    tx_fin_d     = tx_fin_q;
`ifdef TCP_CTRL_RST_REPLY_EN
    tx_rst_d     = tx_rst_q;
`endif
    if (go) begin
      tx_valid_d   = ev_tx;
      tx_conn_id_d = ev_id;
      tx_syn_d     = ev_syn;
      tx_ack_d     = ev_ack;
      tx_fin_d     = ev_fin;
`ifdef TCP_CTRL_RST_REPLY_EN
      tx_rst_d     = ev_rst;
`endif
    end
    evt_error_d  = ev_err;
    stat_state_d = ({1'b0, stat_conn_id} < CONN_LIMIT) ? state_q[stat_conn_id] : ST_CLOSED;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-connection arrays are small flop banks, not RAM, so they are reset explicitly.
      for (int i = 0; i < CONN_COUNT; i++) begin
        state_q[i] <= ST_CLOSED;
        timer_q[i] <= '0;
      end
      tx_valid_q   <= 1'b0;
      tx_conn_id_q <= '0;
      tx_syn_q     <= 1'b0;
      tx_ack_q     <= 1'b0;
      tx_fin_q     <= 1'b0;
      evt_error_q  <= 1'b0;
      stat_state_q <= ST_CLOSED;
    end else begin
      for (int i = 0; i < CONN_COUNT; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      tx_valid_q   <= tx_valid_d;
      tx_conn_id_q <= tx_conn_id_d;
      tx_syn_q     <= tx_syn_d;
      tx_ack_q     <= tx_ack_d;
      tx_fin_q     <= tx_fin_d;
      evt_error_q  <= evt_error_d;
      stat_state_q <= stat_state_d;
    end
  end

`ifdef TCP_CTRL_RST_REPLY_EN
  always_ff @(posedge clk) begin
    if (rst) tx_rst_q <= 1'b0;
    else     tx_rst_q <= tx_rst_d;
  end
  assign m_tx_rst = tx_rst_q;
`else
  assign m_tx_rst = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < CONN_COUNT; i++) conn_established[i] = (state_q[i] == ST_ESTABLISHED);
  end

  assign m_tx_valid   = tx_valid_q;
  assign m_tx_conn_id = tx_conn_id_q;
  assign m_tx_syn     = tx_syn_q;
  assign m_tx_ack     = tx_ack_q;
  assign m_tx_fin     = tx_fin_q;
  assign evt_error    = evt_error_q;
  assign stat_state   = stat_state_q;

endmodule

// File: tb/tb_tcp_conn_ctrl.sv
// Directed bench for tcp_conn_ctrl: handshakes, close paths, 2MSL expiry, backpressure, errors.
// Five connections are instantiated so the 3-bit id can also address nonexistent connections.
`timescale 1ns/1ps
module tb_tcp_conn_ctrl;
  localparam int CONN_COUNT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        timer_tick;
  logic [15:0] timeout_2msl_in;
  logic        s_seg_valid, s_seg_ready, s_seg_syn, s_seg_ack, s_seg_fin, s_seg_rst;
  logic [2:0]  s_seg_conn_id;
  logic        s_cmd_valid, s_cmd_ready;
  logic [2:0]  s_cmd_conn_id;
  logic [1:0]  s_cmd_op;
  logic        m_tx_valid, m_tx_ready, m_tx_syn, m_tx_ack, m_tx_fin, m_tx_rst;
  logic [2:0]  m_tx_conn_id;
  logic [2:0]  stat_conn_id;
  logic [3:0]  stat_state;
  logic [4:0]  conn_established;
  logic        evt_error;

  int total = 0;
  int bad   = 0;

  tcp_conn_ctrl #(.CONN_COUNT(CONN_COUNT), .TIMER_WIDTH(16), .DEFAULT_2MSL_TIMER(16'h1000)) dut (
    .clk(clk), .rst(rst), .timer_tick(timer_tick), .timeout_2msl_in(timeout_2msl_in),
    .s_seg_valid(s_seg_valid), .s_seg_ready(s_seg_ready), .s_seg_conn_id(s_seg_conn_id),
    .s_seg_syn(s_seg_syn), .s_seg_ack(s_seg_ack), .s_seg_fin(s_seg_fin), .s_seg_rst(s_seg_rst),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_conn_id(s_cmd_conn_id),
    .s_cmd_op(s_cmd_op),
    .m_tx_valid(m_tx_valid), .m_tx_ready(m_tx_ready), .m_tx_conn_id(m_tx_conn_id),
    .m_tx_syn(m_tx_syn), .m_tx_ack(m_tx_ack), .m_tx_fin(m_tx_fin), .m_tx_rst(m_tx_rst),
    .stat_conn_id(stat_conn_id), .stat_state(stat_state),
    .conn_established(conn_established), .evt_error(evt_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] txv(input logic v, input logic [2:0] id,
                                      input logic syn, input logic ack, input logic fin, input logic r);
    return {8'h00, v, id, syn, ack, fin, r};
  endfunction

  function automatic logic [15:0] tx_now();
    return {8'h00, m_tx_valid, m_tx_conn_id, m_tx_syn, m_tx_ack, m_tx_fin, m_tx_rst};
  endfunction

  // All tasks start and end on a falling edge; the DUT samples on the rising edge in between.
  task automatic seg(input logic [2:0] id, input logic syn, input logic ack, input logic fin, input logic r);
    s_seg_conn_id = id; s_seg_syn = syn; s_seg_ack = ack; s_seg_fin = fin; s_seg_rst = r;
    s_seg_valid = 1'b1;
    @(negedge clk);
    s_seg_valid = 1'b0; s_seg_syn = 1'b0; s_seg_ack = 1'b0; s_seg_fin = 1'b0; s_seg_rst = 1'b0;
  endtask

  task automatic cmd(input logic [2:0] id, input logic [1:0] op);
    s_cmd_conn_id = id; s_cmd_op = op; s_cmd_valid = 1'b1;
    @(negedge clk);
    s_cmd_valid = 1'b0; s_cmd_op = 2'd0;
  endtask

  task automatic stat(input string tag, input logic [2:0] id, input logic [3:0] exp);
    stat_conn_id = id;
    @(negedge clk);
    check(tag, 16'(stat_state), 16'(exp));
  endtask

  task automatic tick();
    timer_tick = 1'b1;
    @(negedge clk);
    timer_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    rst = 1'b1; timer_tick = 1'b0; timeout_2msl_in = 16'd3;
    s_seg_valid = 1'b0; s_seg_conn_id = '0; s_seg_syn = 1'b0; s_seg_ack = 1'b0;
    s_seg_fin = 1'b0; s_seg_rst = 1'b0;
    s_cmd_valid = 1'b0; s_cmd_conn_id = '0; s_cmd_op = 2'd0;
    m_tx_ready = 1'b1; stat_conn_id = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset_tx", tx_now(), txv(0, 0, 0, 0, 0, 0));
    check("reset_est", 16'(conn_established), 16'h0);
    check("reset_err", 16'(evt_error), 16'h0);
    check("reset_stat", 16'(stat_state), 16'h0);
    check("reset_ready", {14'h0, s_seg_ready, s_cmd_ready}, 16'h3);

    // Active open, connection 0
    cmd(3'd0, 2'd1);
    check("c0_open_tx", tx_now(), txv(1, 0, 1, 0, 0, 0));
    stat("c0_syn_sent", 3'd0, 4'd2);
    seg(3'd0, 1, 1, 0, 0);
    check("c0_synack_tx", tx_now(), txv(1, 0, 0, 1, 0, 0));
    check("c0_est", 16'(conn_established), 16'h01);

    // Passive open, connection 2
    cmd(3'd2, 2'd2);
    check("c2_listen_tx", tx_now(), txv(0, 0, 0, 0, 0, 0) | 16'(m_tx_conn_id) << 4);
    check("c2_listen_err", 16'(evt_error), 16'h0);
    seg(3'd2, 1, 0, 0, 0);
    check("c2_syn_tx", tx_now(), txv(1, 2, 1, 1, 0, 0));
    stat("c2_syn_rcvd", 3'd2, 4'd3);
    seg(3'd2, 0, 1, 0, 0);
    check("c2_ack_notx", 16'(m_tx_valid), 16'h0);
    check("c2_est", 16'(conn_established), 16'h05);
    stat("c2_established", 3'd2, 4'd4);

    // Connection 1 up, then active close through TIME_WAIT expiry
    cmd(3'd1, 2'd1);
    seg(3'd1, 1, 1, 0, 0);
    check("c1_est", 16'(conn_established), 16'h07);
    cmd(3'd1, 2'd3);
    check("c1_close_tx", tx_now(), txv(1, 1, 0, 0, 1, 0));
    check("c1_fw1_est", 16'(conn_established), 16'h05);
    seg(3'd1, 0, 1, 0, 0);
    check("c1_ack_notx", 16'(m_tx_valid), 16'h0);
    stat("c1_fin_wait_2", 3'd1, 4'd6);
    seg(3'd1, 0, 0, 1, 0);
    check("c1_fin_tx", tx_now(), txv(1, 1, 0, 1, 0, 0));
    stat("c1_time_wait", 3'd1, 4'd8);
    tick();
    tick();
    check("c1_tick2_stat", 16'(stat_state), 16'd8);
    tick();
    check("c1_tick3_stat", 16'(stat_state), 16'd8);
    @(negedge clk);
    check("c1_zero_stat", 16'(stat_state), 16'd8);
    @(negedge clk);
    check("c1_expired_stat", 16'(stat_state), 16'd0);

    // Backpressure and segment priority
    m_tx_ready = 1'b0;
    cmd(3'd3, 2'd1);
    check("bp_tx_pending", tx_now(), txv(1, 3, 1, 0, 0, 0));
    check("bp_ready_low", {14'h0, s_seg_ready, s_cmd_ready}, 16'h0);
    s_seg_conn_id = 3'd3; s_seg_syn = 1'b1; s_seg_ack = 1'b1; s_seg_valid = 1'b1;
    s_cmd_conn_id = 3'd4; s_cmd_op = 2'd2; s_cmd_valid = 1'b1;
    @(negedge clk);
    check("bp_tx_held", tx_now(), txv(1, 3, 1, 0, 0, 0));
    m_tx_ready = 1'b1;
    #1;
    check("bp_seg_first", {14'h0, s_seg_ready, s_cmd_ready}, 16'h2);
    @(negedge clk);
    s_seg_valid = 1'b0; s_seg_syn = 1'b0; s_seg_ack = 1'b0;
    check("bp_seg_tx", tx_now(), txv(1, 3, 0, 1, 0, 0));
    #1;
    check("bp_cmd_ready", 16'(s_cmd_ready), 16'h1);
    @(negedge clk);
    s_cmd_valid = 1'b0; s_cmd_op = 2'd0;
    check("bp_cmd_notx", 16'(m_tx_valid), 16'h0);
    check("bp_est", 16'(conn_established), 16'h0D);
    stat("c4_listen", 3'd4, 4'd1);

    // RST aborts an established connection silently
    seg(3'd3, 0, 1, 0, 1);
    check("c3_rst_notx", 16'(m_tx_valid), 16'h0);
    check("c3_rst_err", 16'(evt_error), 16'h0);
    check("c3_rst_est", 16'(conn_established), 16'h05);

    // Nonexistent connection ids and no-op command
    seg(3'd5, 0, 1, 0, 0);
    check("badid_seg_err", 16'(evt_error), 16'h1);
    @(negedge clk);
    check("badid_err_pulse", 16'(evt_error), 16'h0);
    cmd(3'd7, 2'd1);
    check("badid_cmd_err", 16'(evt_error), 16'h1);
    check("badid_cmd_notx", 16'(m_tx_valid), 16'h0);
    cmd(3'd6, 2'd0);
    check("nop_no_err", 16'(evt_error), 16'h0);

    // Illegal pair: SYN to an established connection
    seg(3'd2, 1, 0, 0, 0);
    check("c2_syn_err", 16'(evt_error), 16'h1);
    check("c2_syn_notx", 16'(m_tx_valid), 16'h0);
    stat("c2_still_est", 3'd2, 4'd4);

    // Passive close on connection 2
    seg(3'd2, 0, 0, 1, 0);
    check("c2_fin_tx", tx_now(), txv(1, 2, 0, 1, 0, 0));
    stat("c2_close_wait", 3'd2, 4'd9);
    cmd(3'd2, 2'd3);
    check("c2_close_tx", tx_now(), txv(1, 2, 0, 0, 1, 0));
    stat("c2_last_ack", 3'd2, 4'd10);
    seg(3'd2, 0, 1, 0, 0);
    check("c2_last_notx", 16'(m_tx_valid), 16'h0);
    stat("c2_closed", 3'd2, 4'd0);
    check("c2_done_est", 16'(conn_established), 16'h01);

    // Stray ACK to a CLOSED connection
    seg(3'd3, 0, 1, 0, 0);
`ifdef TCP_CTRL_RST_REPLY_EN
    check("closed_ack_tx", tx_now(), txv(1, 3, 0, 0, 0, 1));
    check("closed_ack_err", 16'(evt_error), 16'h0);
`else
    check("closed_ack_tx", 16'(m_tx_valid), 16'h0);
    check("closed_ack_err", 16'(evt_error), 16'h1);
`endif

    // Reset while a TX request is stalled
    m_tx_ready = 1'b0;
    cmd(3'd1, 2'd1);
    check("mid_tx_pending", tx_now(), txv(1, 1, 1, 0, 0, 0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_tx_ready = 1'b1;
    check("mid_rst_tx", 16'(m_tx_valid), 16'h0);
    check("mid_rst_est", 16'(conn_established), 16'h0);
    stat("mid_rst_stat", 3'd1, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
